mult_par_pipe: RTL and testbench

//  Parametrised pipelined multiplier with even-parity protection on arguments and result, and a req/ack argument handshake.

---
 rtl/mult_par_pkg.sv | 31 +++
 rtl/mult_par_pipe_core.sv | 79 +++++++
 rtl/mult_par_pipe.sv | 90 +++++++++
 tb/tb_mult_par_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_par_pkg.sv
// Shared types, limits and helpers for the parity-protected pipelined multiplier.
// Operand width is bounded by MAX_WIDTH so a single op struct serves every instance.
package mult_par_pkg;

  localparam int MAX_WIDTH   = 32;
  localparam int MIN_WIDTH   = 4;
  localparam int MIN_LATENCY = 2;
  localparam int PAR_W       = 2 * MAX_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } hs_state_e;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 mode;
    logic                 err;
  } mult_op_s;

  function automatic logic even_parity(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

  // Keeps the pipeline at least one internal stage deep for illegal LATENCY values.
  function automatic int clamp_latency(input int lat);
    return (lat < MIN_LATENCY) ? MIN_LATENCY : lat;
  endfunction

endpackage

// File: rtl/mult_par_pipe_core.sv
// Valid/data shift pipeline: product, error flag and parity formed at stage 0,
// registered through, and landed in hold-until-next-result output registers.
module mult_par_pipe_core
  import mult_par_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  mult_op_s           in_op,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               arg_parity_error,
  output logic               result_rdy,
  output logic               done_err
);

  localparam int PW     = 2 * WIDTH;
  localparam int STAGES = clamp_latency(LATENCY) - 1;

  logic [PW-1:0]              ext_a, ext_b, prod_c;
  logic                       par_c;
  logic [STAGES-1:0]          vld_q, err_q, par_q;
  logic [STAGES-1:0][PW-1:0]  prod_q;

  // Sign extension to full product width makes one multiplier serve both modes.
  always_comb begin
    ext_a  = {{WIDTH{in_op.mode & in_op.a[WIDTH-1]}}, in_op.a[WIDTH-1:0]};
    ext_b  = {{WIDTH{in_op.mode & in_op.b[WIDTH-1]}}, in_op.b[WIDTH-1:0]};
    prod_c = in_op.err ? '0 : ext_a * ext_b;
    par_c  = even_parity(PAR_W'(prod_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      err_q  <= '0;
      par_q  <= '0;
      prod_q <= '0;
    end else begin
      vld_q[0]  <= in_valid;
      err_q[0]  <= in_op.err;
      par_q[0]  <= par_c;
      prod_q[0] <= prod_c;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        par_q[i]  <= par_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      result_rdy       <= 1'b0;
    end else begin
      result_rdy <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        result           <= prod_q[STAGES-1];
        result_parity    <= par_q[STAGES-1];
        arg_parity_error <= err_q[STAGES-1];
      end
    end
  end

  assign done_err = vld_q[STAGES-1] & err_q[STAGES-1];

  if (WIDTH < MAX_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{in_op.a[MAX_WIDTH-1:WIDTH], in_op.b[MAX_WIDTH-1:WIDTH]};
  end

endmodule

// File: rtl/mult_par_pipe.sv
// Pipelined multiplier top: req/ack capture with one-cycle cooldown, argument
// parity check, and a saturating count of parity-errored operations.
module mult_par_pipe
  import mult_par_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LATENCY  = 3,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    arg_a,
  input  logic [WIDTH-1:0]    arg_b,
  input  logic                arg_a_parity,
  input  logic                arg_b_parity,
  input  logic                signed_mode,
  input  logic                req,
  output logic                ack,
  output logic [2*WIDTH-1:0]  result,
  output logic                result_parity,
  output logic                result_rdy,
  output logic                arg_parity_error,
  output logic [ERRCNT_W-1:0] err_count
);

  hs_state_e state_q, state_d;
  mult_op_s  op_q;
  logic      capture, a_err, b_err, done_err;

  // ACK state doubles as the cooldown cycle, so req is ignored while ack is high.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ACK;
          capture = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign ack   = (state_q == ST_ACK);
  assign a_err = even_parity(PAR_W'(arg_a)) != arg_a_parity;
  assign b_err = even_parity(PAR_W'(arg_b)) != arg_b_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (capture) begin
      op_q.a    <= MAX_WIDTH'(arg_a);
      op_q.b    <= MAX_WIDTH'(arg_b);
      op_q.mode <= signed_mode;
      op_q.err  <= a_err | b_err;
    end
  end

  mult_par_pipe_core #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_core (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (ack),
    .in_op            (op_q),
    .result           (result),
    .result_parity    (result_parity),
    .arg_parity_error (arg_parity_error),
    .result_rdy       (result_rdy),
    .done_err         (done_err)
  );

  // Counted on the same edge that raises result_rdy for the errored op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (done_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_par_pipe.sv
// Self-checking bench for mult_par_pipe: constant vector table, model-driven
// bursts, error-counter saturation and mid-operation reset, via a scoreboard.
`timescale 1ns/1ps
module tb_mult_par_pipe;

  localparam int WIDTH    = 16;
  localparam int LATENCY  = 3;
  localparam int ERRCNT_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [WIDTH-1:0]    arg_a, arg_b;
  logic                arg_a_parity, arg_b_parity, signed_mode, req;
  logic                ack, result_parity, result_rdy, arg_parity_error;
  logic [2*WIDTH-1:0]  result;
  logic [ERRCNT_W-1:0] err_count;

  typedef struct {
    logic [31:0] result;
    logic        par;
    logic        perr;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        pa;
    logic        pb;
    logic        mode;
    logic [31:0] exp_result;
    logic        exp_par;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  int          ack_q[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ack_count = 0;
  int          last_ack = -10;
  int          exp_err_cnt = 0;
  logic [31:0] last_result = '0;

  mult_par_pipe #(
    .WIDTH    (WIDTH),
    .LATENCY  (LATENCY),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arg_a            (arg_a),
    .arg_b            (arg_b),
    .arg_a_parity     (arg_a_parity),
    .arg_b_parity     (arg_b_parity),
    .signed_mode      (signed_mode),
    .req              (req),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic pa, input logic pb, input logic mode);
    exp_t                e;
    logic signed [63:0]  sp;
    if (((^a) != pa) || ((^b) != pb)) begin
      e.result = '0;
      e.par    = 1'b0;
      e.perr   = 1'b1;
    end else begin
      if (mode) sp = $signed(a) * $signed(b);
      else      sp = $signed({48'b0, a}) * $signed({48'b0, b});
      e.result = sp[31:0];
      e.par    = ^sp[31:0];
      e.perr   = 1'b0;
    end
    return e;
  endfunction

  // Monitor: cooldown spacing on ack, and in-order result checking against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (rst_n) begin
      if (ack) begin
        checkOutput("ack_gap", 64'((cyc - last_ack) >= 2), 64'd1);
        last_ack = cyc;
        ack_q.push_back(cyc);
        ack_count++;
      end
      if (result_rdy) begin
        if (exp_q.size() == 0 || ack_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_rdy: got result_rdy=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          t = ack_q.pop_front();
          if (e.perr && exp_err_cnt < 255) exp_err_cnt++;
          checkOutput("latency", 64'(cyc - t), 64'(LATENCY));
          checkOutput("result", 64'(result), 64'(e.result));
          checkOutput("result_parity", 64'(result_parity), 64'(e.par));
          checkOutput("arg_parity_error", 64'(arg_parity_error), 64'(e.perr));
          checkOutput("err_count", 64'(err_count), 64'(exp_err_cnt));
          last_result = e.result;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic pa,
                               input logic pb, input logic mode, input exp_t e,
                               input bit keep_req, output int ack_cyc);
    bit seen = 1'b0;
    arg_a        = a;
    arg_b        = b;
    arg_a_parity = pa;
    arg_b_parity = pb;
    signed_mode  = mode;
    req          = 1'b1;
    ack_cyc      = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      exp_q.push_back(e);
      ack_cyc = cyc;
    end else begin
      checks++;
      fails++;
      $display("[TB] FAIL ack_timeout: got no ack, expected ack within 10 cycles");
    end
    if (!keep_req || !seen) req = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
      ack_q.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ack"}, 64'(ack), 64'd0);
    checkOutput({tag, "_rdy"}, 64'(result_rdy), 64'd0);
    checkOutput({tag, "_result"}, 64'(result), 64'd0);
    checkOutput({tag, "_parity"}, 64'(result_parity), 64'd0);
    checkOutput({tag, "_perr"}, 64'(arg_parity_error), 64'd0);
    checkOutput({tag, "_errcnt"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    exp_t e;
    int   ac;
    int   burst_ack[4];
    int   acks_before;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h0003, 16'hFFFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 32'h4000_0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0002, 1'b0, 1'b1, 1'b0, 32'h0001_FFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0003, 16'h0002, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 32'h4000_0000, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE_0001, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1, 32'hC000_8000, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[9] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};

    rst_n = 1'b0;
    req = 1'b0;
    arg_a = '0;
    arg_b = '0;
    arg_a_parity = 1'b0;
    arg_b_parity = 1'b0;
    signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      e.result = vecs[i].exp_result;
      e.par    = vecs[i].exp_par;
      e.perr   = vecs[i].exp_err;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].pa, vecs[i].pb, vecs[i].mode, e, 1'b0, ac);
    end
    waitDrain();

    $display("[TB] req held high for 4 ops");
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      e = model(ra, rb, ^ra, ^rb, 1'(i));
      applyStimulus(ra, rb, ^ra, ^rb, 1'(i), e, i != 3, burst_ack[i]);
    end
    for (int i = 1; i < 4; i++) checkOutput("burst_ack_spacing", 64'(burst_ack[i] - burst_ack[i-1]), 64'd2);
    waitDrain();
    repeat (2) @(negedge clk);
    checkOutput("result_hold", 64'(result), 64'(last_result));

    $display("[TB] req pulse dropped before capture");
    acks_before = ack_count;
    req = 1'b1;
    #2 req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no_ack_on_dropped_req", 64'(ack_count), 64'(acks_before));

    $display("[TB] error counter saturation");
    for (int i = 0; i < 256; i++) begin
      e = model(16'h0003, 16'h0002, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h0003, 16'h0002, 1'b1, 1'b1, 1'b0, e, i != 255, ac);
    end
    waitDrain();
    checkOutput("err_count_saturated", 64'(err_count), 64'hFF);

    $display("[TB] reset mid-operation");
    e = model(16'h1234, 16'h0101, ^16'h1234, ^16'h0101, 1'b0);
    applyStimulus(16'h1234, 16'h0101, ^16'h1234, ^16'h0101, 1'b0, e, 1'b0, ac);
    waitDrain();
    e = model(16'h00FF, 16'h0011, ^16'h00FF, ^16'h0011, 1'b1);
    applyStimulus(16'h00FF, 16'h0011, ^16'h00FF, ^16'h0011, 1'b1, e, 1'b0, ac);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    ack_q.delete();
    exp_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    e = model(16'hFFF0, 16'h0007, ^16'hFFF0, ^16'h0007, 1'b1);
    applyStimulus(16'hFFF0, 16'h0007, ^16'hFFF0, ^16'h0007, 1'b1, e, 1'b0, ac);
    waitDrain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
